// File: rtl/aes_pkg.sv
// Shared widths, mode encodings and FSM state codes for the AES CBC controller.
// Latency: none (constants only).
// Backpressure: not applicable.
package aes_pkg;
  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CRST = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;
endpackage

// File: rtl/aes_cbc_ctrl_if.sv
// Block stream between the front end and the CBC controller: input and output valid/ready channels.
// Latency: wires only.
// Backpressure: in_ready / out_ready carry the usual valid/ready semantics.
interface aes_cbc_ctrl_if;
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;

  // front end side: produces input blocks, consumes results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_cbc_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags expiry on the TIMEOUT_CYCLES-th one.
// Latency: o_expired is combinational from the count, asserted in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; saturates at expiry until cleared.
module aes_cbc_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // count enabled cycles, holding once expired so the flag cannot wrap away
  always_ff @(posedge Clk) begin
    if (Rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller driving an external AES_256 core through its reset/En/done handshake.
// Latency: accept -> 1 core-reset cycle -> core latency -> result held; one block per (core latency + 3) cycles.
// Backpressure: in_ready only in IDLE; a result is held stable in HOLD until out_ready.
module aes_cbc_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic [BLK_W-1:0]  cfg_iv,
  input  logic              cfg_decrypt,
  input  logic              cfg_load,
  aes_cbc_ctrl_if.slave     io,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_encryp_decrypt,
  output logic [BLK_W-1:0]  core_data_in,
  output logic              core_rst_n,
  output logic              core_en,
  input  logic [BLK_W-1:0]  core_data_out,
  input  logic              core_done,
  output logic [CNT_W-1:0]  blk_count,
  output logic              err_timeout
);
  logic [1:0]       r_state;
  logic [KEY_W-1:0] r_key;
  logic             r_mode;
  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] r_ct_hold;
  logic [BLK_W-1:0] r_core_din;
  logic [BLK_W-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_in_fire;
  logic             w_expired;
  logic             w_run;

  assign w_run     = (r_state == ST_RUN);
  // a cfg_load cycle must not also swallow a block; Rst gating keeps in_ready low while in reset
  assign io.in_ready  = (r_state == ST_IDLE) && !cfg_load && !Rst;
  assign w_in_fire    = io.in_valid && io.in_ready;
  assign io.out_valid = (r_state == ST_HOLD);
  assign io.out_data  = r_res;

  // the core is held in reset everywhere except RUN, so each block starts from a clean core
  assign core_rst_n          = w_run;
  assign core_en             = w_run;
  assign core_key            = r_key;
  assign core_encryp_decrypt = ~r_mode;
  assign core_data_in        = r_core_din;
  assign blk_count           = r_cnt;
  assign err_timeout         = r_err;

  aes_cbc_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_clr     (!w_run),
    .i_en      (w_run),
    .o_expired (w_expired)
  );

  // block sequencing, chaining state and configuration latch
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_key      <= '0;
      r_mode     <= MODE_ENC;
      r_chain    <= '0;
      r_ct_hold  <= '0;
      r_core_din <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_load) begin
            r_key   <= cfg_key;
            r_mode  <= cfg_decrypt;
            r_chain <= cfg_iv;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end else if (w_in_fire) begin
            if (r_mode == MODE_DEC) begin
              r_core_din <= io.in_data;
              r_ct_hold  <= io.in_data;
            end else begin
              r_core_din <= io.in_data ^ r_chain;
            end
            r_state <= ST_CRST;
          end
        end
        ST_CRST: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // done wins over a same-cycle expiry: the result is already valid
          if (core_done) begin
            if (r_mode == MODE_DEC) begin
              r_res   <= core_data_out ^ r_chain;
              r_chain <= r_ct_hold;
            end else begin
              r_res   <= core_data_out;
              r_chain <= core_data_out;
            end
            r_state <= ST_HOLD;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (io.out_ready) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule
